route_bank_ram: RTL and testbench

ROUTE_BANK_RAM -- requirements
Module: route_bank_ram

---
 rtl/route_bank_ram.sv | 207 ++++++++++++++++++++
 tb/tb_route_bank_ram.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_bank_ram.sv
// Double-banked route entry RAM: one bank streams out while the other is refilled
// from a neighbour replica or from its own output; banks swap when a frame finishes.
module route_bank_ram #(
    parameter int unsigned CITY_NUM = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CNT_W    = $clog2(CITY_NUM)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [1:0]        command_i,
    input  logic              start_i,
    input  logic              prev_valid_i,
    input  logic [DATA_W-1:0] prev_data_i,
    input  logic              folw_valid_i,
    input  logic [DATA_W-1:0] folw_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              rbank_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [1:0] CmdNop  = 2'd0;
    localparam logic [1:0] CmdPrev = 2'd1;
    localparam logic [1:0] CmdFolw = 2'd2;
    localparam logic [1:0] CmdSelf = 2'd3;

    localparam logic [CNT_W-1:0] LastAddr = CNT_W'(CITY_NUM - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic               rbank_q, rbank_d;
    logic [CNT_W-1:0]   rcount_q, rcount_d;
    logic [CNT_W-1:0]   wcount_q, wcount_d;
    logic               rd_active_q, rd_active_d;
    logic               rd_done_q, rd_done_d;
    logic               wr_done_q, wr_done_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_last_q, s1_last_d;
    logic [DATA_W-1:0]  s1_data_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;

    logic [DATA_W-1:0]  mem_q [2][CITY_NUM];

    logic               rd_en;
    logic               wr_en;
    logic               wr_last_now;
    logic               rd_last_now;
    logic               src_valid;
    logic [DATA_W-1:0]  src_data;

    // Last entry reaches the output register on this edge.
    assign rd_last_now = s1_valid_q & s1_last_q;

    always_comb begin
        src_valid = 1'b0;
        src_data  = '0;
        case (cmd_q)
            CmdPrev: begin
                src_valid = prev_valid_i;
                src_data  = prev_data_i;
            end
            CmdFolw: begin
                src_valid = folw_valid_i;
                src_data  = folw_data_i;
            end
            CmdSelf: begin
                src_valid = out_valid_q;
                src_data  = out_data_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rbank_d     = rbank_q;
        rcount_d    = rcount_q;
        wcount_d    = wcount_q;
        rd_active_d = rd_active_q;
        rd_done_d   = rd_done_q;
        wr_done_d   = wr_done_q;
        err_d       = err_q;
        done_d      = 1'b0;
        s1_valid_d  = 1'b0;
        s1_last_d   = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        wr_last_now = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (prev_valid_i || folw_valid_i) begin
                    err_d = 1'b1;
                end
                if (start_i && (command_i != CmdNop)) begin
                    state_d     = StRun;
                    cmd_d       = command_i;
                    rcount_d    = '0;
                    wcount_d    = '0;
                    rd_active_d = 1'b1;
                    rd_done_d   = 1'b0;
                    wr_done_d   = 1'b0;
                end
            end
            StRun: begin
                if (start_i) begin
                    err_d = 1'b1;
                end
                if (rd_active_q) begin
                    rd_en      = 1'b1;
                    s1_valid_d = 1'b1;
                    s1_last_d  = (rcount_q == LastAddr);
                    if (rcount_q == LastAddr) begin
                        rcount_d    = '0;
                        rd_active_d = 1'b0;
                    end else begin
                        rcount_d = rcount_q + CNT_W'(1);
                    end
                end
                if (rd_last_now) begin
                    rd_done_d = 1'b1;
                end
                if (src_valid) begin
                    if (wr_done_q) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (wcount_q == LastAddr) begin
                            wcount_d    = '0;
                            wr_done_d   = 1'b1;
                            wr_last_now = 1'b1;
                        end else begin
                            wcount_d = wcount_q + CNT_W'(1);
                        end
                    end
                end
                // Completion may coincide with the final read or write event itself.
                if ((rd_done_q || rd_last_now) && (wr_done_q || wr_last_now)) begin
                    state_d = StIdle;
                    rbank_d = ~rbank_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cmd_q       <= CmdNop;
            rbank_q     <= 1'b0;
            rcount_q    <= '0;
            wcount_q    <= '0;
            rd_active_q <= 1'b0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rbank_q     <= rbank_d;
            rcount_q    <= rcount_d;
            wcount_q    <= wcount_d;
            rd_active_q <= rd_active_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= s1_valid_q;
            out_data_q  <= s1_data_q;
        end
    end

    // Storage is deliberately left out of reset so partial frames survive an abort.
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            s1_data_q <= mem_q[rbank_q][rcount_q];
        end
        if (wr_en && !reset_i) begin
            mem_q[~rbank_q][wcount_q] <= src_data;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign rbank_o     = rbank_q;
    assign busy_o      = (state_q == StRun);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_route_bank_ram.sv
// Randomized bench for route_bank_ram with a per-frame bank model (CITY_NUM=4, DATA_W=8).
module tb_route_bank_ram;

    localparam int CITY = 4;
    localparam logic [1:0] CmdNop  = 2'd0;
    localparam logic [1:0] CmdPrev = 2'd1;
    localparam logic [1:0] CmdFolw = 2'd2;
    localparam logic [1:0] CmdSelf = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] command;
    logic       start;
    logic       prev_valid;
    logic [7:0] prev_data;
    logic       folw_valid;
    logic [7:0] folw_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       rbank;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents, which entries are defined, active bank, sticky error.
    logic [7:0] m_mem   [2][CITY];
    logic       m_known [2][CITY];
    logic       m_rbank;
    logic       m_err;

    route_bank_ram #(
        .CITY_NUM(CITY),
        .DATA_W  (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .command_i   (command),
        .start_i     (start),
        .prev_valid_i(prev_valid),
        .prev_data_i (prev_data),
        .folw_valid_i(folw_valid),
        .folw_data_i (folw_data),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .rbank_o     (rbank),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset   = 1'b0;
        m_rbank = 1'b0;
        m_err   = 1'b0;
    endtask

    // Runs one frame; k counts cycles after the start-sampling edge.
    task automatic run_frame(input logic [1:0] cmd, input logic use_pat, input logic [15:0] pat,
                             input logic rand_data, input logic [7:0] base,
                             input logic extra, input logic stray);
        logic [7:0] wdat   [CITY];
        logic [7:0] exp_rd [CITY];
        logic       exp_kn [CITY];
        logic       rb;
        logic       v;
        logic       extra_sent;
        logic       exp_ov;
        logic       exp_busy;
        logic       exp_done;
        int         writes;
        int         w;
        int         f;
        rb = m_rbank;
        for (int i = 0; i < CITY; i++) begin
            exp_rd[i] = m_mem[rb][i];
            exp_kn[i] = m_known[rb][i];
            wdat[i]   = rand_data ? 8'($urandom) : base + 8'(i);
        end
        command = cmd;
        start   = 1'b1;
        step();
        start      = 1'b0;
        command    = CmdNop;
        writes     = 0;
        w          = (cmd == CmdSelf) ? CITY + 2 : -1;
        f          = -1;
        extra_sent = 1'b0;
        for (int k = 0; k < 40; k++) begin
            f        = (w < 0) ? -1 : ((w > CITY + 1) ? w : CITY + 1);
            exp_ov   = (k >= 2) && (k <= CITY + 1);
            exp_busy = (f < 0) ? 1'b1 : (k < f);
            exp_done = (k == f);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL out_valid cmd=%0d k=%0d got=%b exp=%b", cmd, k, out_valid, exp_ov);
            end
            if (exp_ov && exp_kn[k-2]) begin
                checks++;
                if (out_data !== exp_rd[k-2]) begin
                    errors++;
                    $display("FAIL out_data cmd=%0d k=%0d got=%h exp=%h", cmd, k, out_data,
                             exp_rd[k-2]);
                end
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cmd=%0d k=%0d got=%b exp=%b", cmd, k, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done cmd=%0d k=%0d got=%b exp=%b", cmd, k, done, exp_done);
            end
            if (f >= 0 && k > f && (!extra || extra_sent)) break;
            prev_valid = 1'b0;
            folw_valid = 1'b0;
            prev_data  = 8'($urandom);
            folw_data  = 8'($urandom);
            start      = 1'b0;
            command    = CmdNop;
            if (stray && k == 1) begin
                start   = 1'b1;
                command = CmdFolw;
            end
            if (cmd != CmdSelf) begin
                v = 1'b0;
                if (writes < CITY) begin
                    v = use_pat ? ((k < 16) ? pat[k] : 1'b1) : ($urandom_range(0, 99) < 60);
                    if (v) begin
                        if (cmd == CmdPrev) prev_data = wdat[writes];
                        else                folw_data = wdat[writes];
                        writes++;
                        if (writes == CITY) w = k + 1;
                    end
                end else if (extra && !extra_sent) begin
                    v          = 1'b1;
                    extra_sent = 1'b1;
                end
                if (cmd == CmdPrev) prev_valid = v;
                else                folw_valid = v;
            end
            // Non-selected sources toggle only while the frame is certainly still running.
            if (k + 1 <= CITY + 1) begin
                if (cmd != CmdPrev) prev_valid = 1'($urandom_range(0, 1));
                if (cmd != CmdFolw) folw_valid = 1'($urandom_range(0, 1));
            end
            step();
        end
        prev_valid = 1'b0;
        folw_valid = 1'b0;
        start      = 1'b0;
        checks++;
        if (f < 0) begin
            errors++;
            $display("FAIL frame_timeout cmd=%0d got=no_completion exp=completion", cmd);
        end
        for (int i = 0; i < CITY; i++) begin
            m_mem[~rb][i]   = (cmd == CmdSelf) ? exp_rd[i] : wdat[i];
            m_known[~rb][i] = (cmd == CmdSelf) ? exp_kn[i] : 1'b1;
        end
        m_rbank = ~rb;
        if (extra || stray) m_err = 1'b1;
        checks++;
        if (rbank !== m_rbank) begin
            errors++;
            $display("FAIL rbank_after_frame cmd=%0d got=%b exp=%b", cmd, rbank, m_rbank);
        end
        checks++;
        if (err !== m_err) begin
            errors++;
            $display("FAIL err_after_frame cmd=%0d got=%b exp=%b", cmd, err, m_err);
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if ({out_valid, busy, done, err, rbank} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=00000", {out_valid, busy, done, err, rbank});
        end
    endtask

    task automatic test_prev_then_self();
        run_frame(CmdPrev, 1'b1, 16'hFFFF, 1'b0, 8'h10, 1'b0, 1'b0);
        run_frame(CmdSelf, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(CmdSelf, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_folw_bubbles();
        run_frame(CmdFolw, 1'b1, 16'b0000_0000_0101_1001, 1'b0, 8'hA0, 1'b0, 1'b0);
        run_frame(CmdSelf, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_frame(2'($urandom_range(1, 3)), 1'b0, 16'h0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic test_errors();
        logic rb0;
        rb0        = m_rbank;
        prev_valid = 1'b1;
        prev_data  = 8'hEE;
        step();
        prev_valid = 1'b0;
        m_err      = 1'b1;
        step();
        checks++;
        if (err !== 1'b1 || rbank !== rb0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid got=err%b/rbank%b/busy%b exp=err1/rbank%b/busy0",
                     err, rbank, busy, rb0);
        end
        run_frame(CmdSelf, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(CmdPrev, 1'b0, 16'h0, 1'b1, 8'h00, 1'b0, 1'b1);
        do_reset(1);
        checks++;
        if (err !== 1'b0 || rbank !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got=err%b/rbank%b exp=err0/rbank0", err, rbank);
        end
        run_frame(CmdPrev, 1'b1, 16'hFFFF, 1'b1, 8'h00, 1'b1, 1'b0);
        run_frame(CmdSelf, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset(2);
    endtask

    task automatic test_reset_mid();
        command = CmdSelf;
        start   = 1'b1;
        step();
        start   = 1'b0;
        command = CmdNop;
        repeat (4) step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== m_mem[0][2]) begin
            errors++;
            $display("FAIL third_out got=%b/%h exp=1/%h", out_valid, out_data, m_mem[0][2]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got=ov%b/busy%b/done%b exp=0/0/0", out_valid, busy, done);
        end
        for (int i = 0; i < 2; i++) begin
            m_mem[1][i]   = m_mem[0][i];
            m_known[1][i] = m_known[0][i];
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (done !== 1'b0 || rbank !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c=%0d got=done%b/rbank%b exp=0/0", c, done, rbank);
            end
            step();
        end
        run_frame(CmdSelf, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        command    = CmdNop;
        start      = 1'b0;
        prev_valid = 1'b0;
        prev_data  = '0;
        folw_valid = 1'b0;
        folw_data  = '0;
        m_rbank    = 1'b0;
        m_err      = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < CITY; i++) begin
                m_mem[b][i]   = '0;
                m_known[b][i] = 1'b0;
            end
        end
        #1;
        test_reset();
        test_prev_then_self();
        test_folw_bubbles();
        test_random();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
